// File: rtl/comparator_reg_if.sv
// ---------------------------------------------------------------------------
// comparator_reg_if
//   Bundles the operand/control inputs and the registered result outputs of
//   the comparator_reg compare stage.
//
//   Signals:
//     in_valid    : a/b/signed_mode are valid this cycle
//     a, b        : WIDTH-bit operands
//     signed_mode : 0 = unsigned compare, 1 = two's-complement compare
//     cnt_clr     : synchronous clear of all event counters
//     out_valid   : one-cycle pulse per accepted input, flags updated
//     alb/aeb/agb : one-hot A<B / A==B / A>B flags (all 0 before first input)
//     lt_count, eq_count, gt_count : saturating per-outcome event counters
//
//   Modports:
//     master : the producer of operands / consumer of results
//     slave  : the comparator itself
// ---------------------------------------------------------------------------
interface comparator_reg_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             cnt_clr;
    logic             out_valid;
    logic             alb;
    logic             aeb;
    logic             agb;
    logic [CNT_W-1:0] lt_count;
    logic [CNT_W-1:0] eq_count;
    logic [CNT_W-1:0] gt_count;

    modport master (
        output in_valid, a, b, signed_mode, cnt_clr,
        input  out_valid, alb, aeb, agb, lt_count, eq_count, gt_count
    );

    modport slave (
        input  in_valid, a, b, signed_mode, cnt_clr,
        output out_valid, alb, aeb, agb, lt_count, eq_count, gt_count
    );
endinterface

// File: rtl/comparator_reg.sv
// ---------------------------------------------------------------------------
// comparator_reg
//   Pipelined (1-cycle latency) magnitude comparator for two WIDTH-bit
//   operands, unsigned or two's-complement, with saturating per-outcome
//   event counters for datapath monitoring. All outputs are registered.
//
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset (overrides in_valid and cnt_clr)
//     bus : comparator_reg_if.slave - operands, mode, counter clear in;
//           out_valid, one-hot flags and event counters out
// ---------------------------------------------------------------------------
module comparator_reg #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    comparator_reg_if.slave  bus
);

    // Signed compare is done as an unsigned compare after inverting the
    // sign bits: this maps -2^(W-1)..2^(W-1)-1 monotonically onto 0..2^W-1.
    logic [WIDTH-1:0] sign_flip;
    logic [WIDTH-1:0] a_adj;
    logic [WIDTH-1:0] b_adj;
    logic             lt_d;
    logic             eq_d;
    logic             gt_d;
    logic [2:0]       hit;      // [0]=lt, [1]=eq, [2]=gt, qualified by in_valid

    always_comb begin
        sign_flip            = '0;
        sign_flip[WIDTH-1]   = bus.signed_mode;
        a_adj                = bus.a ^ sign_flip;
        b_adj                = bus.b ^ sign_flip;
        lt_d                 = (a_adj < b_adj);
        eq_d                 = (bus.a == bus.b);
        gt_d                 = (a_adj > b_adj);
        hit                  = {gt_d, eq_d, lt_d} & {3{bus.in_valid}};
    end

    // Result flags and valid pulse. Flags hold when no input is accepted.
    logic out_valid_q;
    logic alb_q;
    logic aeb_q;
    logic agb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alb_q       <= 1'b0;
            aeb_q       <= 1'b0;
            agb_q       <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                alb_q <= lt_d;
                aeb_q <= eq_d;
                agb_q <= gt_d;
            end
        end
    end

    // Three identical saturating counters, one per outcome. Clear takes
    // priority over an increment in the same cycle.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (bus.cnt_clr) begin
                cnt_d = '0;
            end else if (hit[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.alb       = alb_q;
    assign bus.aeb       = aeb_q;
    assign bus.agb       = agb_q;
    assign bus.lt_count  = g_cnt[0].cnt_q;
    assign bus.eq_count  = g_cnt[1].cnt_q;
    assign bus.gt_count  = g_cnt[2].cnt_q;

endmodule

// File: tb/tb_comparator_reg.sv
// ---------------------------------------------------------------------------
// tb_comparator_reg
//   Directed self-checking bench for comparator_reg (WIDTH=4, CNT_W=8).
//   Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_comparator_reg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_LT   = 3'b100;   // {alb, aeb, agb}
    localparam logic [2:0] F_EQ   = 3'b010;
    localparam logic [2:0] F_GT   = 3'b001;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    comparator_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    comparator_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample after the edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                        input logic sm, input logic clr, input logic rs);
        bus.in_valid    = v;
        bus.a           = aa;
        bus.b           = bb;
        bus.signed_mode = sm;
        bus.cnt_clr     = clr;
        rst             = rs;
        @(posedge clk);
        @(negedge clk);
        $display("t=%0t v=%0b a=%0d b=%0d sm=%0b clr=%0b rst=%0b -> ov=%0b flags=%b cnt lt=%0d eq=%0d gt=%0d",
                 $time, v, aa, bb, sm, clr, rs, bus.out_valid, {bus.alb, bus.aeb, bus.agb},
                 bus.lt_count, bus.eq_count, bus.gt_count);
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [2:0] flags);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, ".flags"}, 32'({bus.alb, bus.aeb, bus.agb}), 32'(flags));
    endtask

    task automatic chk_cnt(input string tag, input int lt, input int eq, input int gt);
        chk({tag, ".lt_count"}, 32'(bus.lt_count), 32'(lt));
        chk({tag, ".eq_count"}, 32'(bus.eq_count), 32'(eq));
        chk({tag, ".gt_count"}, 32'(bus.gt_count), 32'(gt));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        // Reset
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk_out("reset", 1'b0, F_NONE);
        chk_cnt("reset", 0, 0, 0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk_out("idle_before_first", 1'b0, F_NONE);

        // 1. Unsigned pairs
        step(1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0); chk_out("u(0,0)",  1'b1, F_EQ);
        step(1'b1, 4'd1,  4'd0,  1'b0, 1'b0, 1'b0); chk_out("u(1,0)",  1'b1, F_GT);
        step(1'b1, 4'd4,  4'd4,  1'b0, 1'b0, 1'b0); chk_out("u(4,4)",  1'b1, F_EQ);
        step(1'b1, 4'd7,  4'd0,  1'b0, 1'b0, 1'b0); chk_out("u(7,0)",  1'b1, F_GT);
        step(1'b1, 4'd8,  4'd15, 1'b0, 1'b0, 1'b0); chk_out("u(8,15)", 1'b1, F_LT);
        step(1'b1, 4'd15, 4'd7,  1'b0, 1'b0, 1'b0); chk_out("u(15,7)", 1'b1, F_GT);
        step(1'b1, 4'd5,  4'd4,  1'b0, 1'b0, 1'b0); chk_out("u(5,4)",  1'b1, F_GT);
        chk_cnt("after_unsigned", 1, 2, 4);

        // 2. Signed pairs, then the same pairs unsigned
        step(1'b1, 4'd8,  4'd7,  1'b1, 1'b0, 1'b0); chk_out("s(8,7)",   1'b1, F_LT);
        step(1'b1, 4'd15, 4'd0,  1'b1, 1'b0, 1'b0); chk_out("s(15,0)",  1'b1, F_LT);
        step(1'b1, 4'd7,  4'd8,  1'b1, 1'b0, 1'b0); chk_out("s(7,8)",   1'b1, F_GT);
        step(1'b1, 4'd12, 4'd12, 1'b1, 1'b0, 1'b0); chk_out("s(12,12)", 1'b1, F_EQ);
        chk_cnt("after_signed", 3, 3, 5);
        step(1'b1, 4'd8,  4'd7,  1'b0, 1'b0, 1'b0); chk_out("u(8,7)",   1'b1, F_GT);
        step(1'b1, 4'd15, 4'd0,  1'b0, 1'b0, 1'b0); chk_out("u(15,0)",  1'b1, F_GT);
        step(1'b1, 4'd7,  4'd8,  1'b0, 1'b0, 1'b0); chk_out("u(7,8)",   1'b1, F_LT);
        step(1'b1, 4'd12, 4'd12, 1'b0, 1'b0, 1'b0); chk_out("u(12,12)", 1'b1, F_EQ);
        chk_cnt("after_resigned", 4, 4, 7);

        // 3. Single pulse then hold (operands change while idle to prove they are ignored)
        step(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        chk_out("pulse", 1'b1, F_GT);
        chk_cnt("pulse", 4, 4, 8);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0);
            chk_out("hold", 1'b0, F_GT);
            chk_cnt("hold", 4, 4, 8);
        end

        // 4. Clear, then saturate eq_count
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk_out("clr_idle", 1'b0, F_GT);
        chk_cnt("clr_idle", 0, 0, 0);
        for (int k = 1; k <= (1 << CNT_W) + 5; k++) begin
            step(1'b1, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0);
            chk("sat.eq_count", 32'(bus.eq_count), 32'((k > 255) ? 255 : k));
        end
        chk_out("sat", 1'b1, F_EQ);
        chk_cnt("sat", 0, 255, 0);

        // 5a. Reset while streaming
        step(1'b1, 4'd2, 4'd9, 1'b0, 1'b0, 1'b0);
        chk_out("stream(2,9)", 1'b1, F_LT);
        chk_cnt("stream(2,9)", 1, 255, 0);
        step(1'b1, 4'd2, 4'd9, 1'b0, 1'b0, 1'b1);
        chk_out("rst_stream", 1'b0, F_NONE);
        chk_cnt("rst_stream", 0, 0, 0);
        step(1'b0, 4'd2, 4'd9, 1'b0, 1'b0, 1'b0);
        chk_out("rst_dropped", 1'b0, F_NONE);
        chk_cnt("rst_dropped", 0, 0, 0);

        // 5b. cnt_clr together with in_valid
        step(1'b1, 4'd9, 4'd2, 1'b0, 1'b0, 1'b0);
        chk_out("u(9,2)", 1'b1, F_GT);
        chk_cnt("u(9,2)", 0, 0, 1);
        step(1'b1, 4'd9, 4'd2, 1'b0, 1'b1, 1'b0);
        chk_out("clr_valid", 1'b1, F_GT);
        chk_cnt("clr_valid", 0, 0, 0);
        step(1'b1, 4'd2, 4'd9, 1'b0, 1'b0, 1'b0);
        chk_out("after_clr", 1'b1, F_LT);
        chk_cnt("after_clr", 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
